// File: rtl/ser_mem_pkg.sv
// Shared opcodes, response bytes and FSM state encoding for the serial
// memory access engine.
package ser_mem_pkg;

    localparam int ADDR_W_DEF = 20;

    localparam logic [7:0] OP_PING     = 8'h00;
    localparam logic [7:0] OP_SET_ADDR = 8'h01;
    localparam logic [7:0] OP_WRITE    = 8'h02;
    localparam logic [7:0] OP_READ     = 8'h03;

    localparam logic [7:0] PING_RSP_DEF = 8'hA5;
    localparam logic [7:0] ACK_BYTE_DEF = 8'h06;
    localparam logic [7:0] NAK_BYTE_DEF = 8'h15;

    typedef enum logic [3:0] {
        S_CMD,
        S_ADDR,
        S_CNT,
        S_WDATA,
        S_WREQ,
        S_WWAIT,
        S_RREQ,
        S_RWAIT,
        S_RTX,
        S_TX
    } state_t;

endpackage

// File: rtl/ser_byte_io.sv
// UART FIFO byte handshake: registered pop/push strobes followed by one
// gap cycle so the FIFO flags have settled before they are sampled again.
module ser_byte_io (
    input  logic       mclk,
    input  logic       reset,
    input  logic [7:0] sio_rxd,
    input  logic       sio_rxempty,
    output logic       sio_rxe,
    output logic [7:0] sio_txd,
    input  logic       sio_txfull,
    output logic       sio_txe,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    input  logic       rx_take,
    output logic       tx_ready,
    input  logic       tx_send,
    input  logic [7:0] tx_byte
);

    logic       rxe_reg;
    logic       txe_reg;
    logic       gap_reg;
    logic [7:0] txd_reg;
    logic       busy;

    // Strobe cycle plus the following gap cycle both block new handshakes.
    assign busy     = rxe_reg | txe_reg | gap_reg;
    assign rx_valid = ~sio_rxempty & ~busy;
    assign rx_byte  = sio_rxd;
    assign tx_ready = ~sio_txfull & ~busy;

    always_ff @(posedge mclk) begin
        if (reset) begin
            rxe_reg <= 1'b0;
            txe_reg <= 1'b0;
            gap_reg <= 1'b0;
            txd_reg <= 8'h00;
        end else begin
            rxe_reg <= rx_take & rx_valid;
            txe_reg <= tx_send & tx_ready;
            gap_reg <= rxe_reg | txe_reg;
            if (tx_send && tx_ready) begin
                txd_reg <= tx_byte;
            end
        end
    end

    assign sio_rxe = rxe_reg;
    assign sio_txe = txe_reg;
    assign sio_txd = txd_reg;

endmodule

// File: rtl/ser_mem_proto.sv
// Binary command parser bridging the UART FIFOs to the SRAM controller:
// PING, SET_ADDR, burst WRITE and burst READ with one request in flight.
module ser_mem_proto
    import ser_mem_pkg::*;
#(
    parameter int         ADDR_W   = ADDR_W_DEF,
    parameter logic [7:0] PING_RSP = PING_RSP_DEF,
    parameter logic [7:0] ACK_BYTE = ACK_BYTE_DEF,
    parameter logic [7:0] NAK_BYTE = NAK_BYTE_DEF
) (
    input  logic              mclk,
    input  logic              reset,
    input  logic [7:0]        sio_rxd,
    input  logic              sio_rxempty,
    output logic              sio_rxe,
    output logic [7:0]        sio_txd,
    input  logic              sio_txfull,
    output logic              sio_txe,
    output logic              mem_begin_wr,
    output logic              mem_begin_rd,
    input  logic              mem_finish,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data_wr,
    input  logic [7:0]        mem_data_rd
);

    state_t            state_reg,   state_next;
    logic [ADDR_W-1:0] addr_reg,    addr_next;
    logic [8:0]        cnt_reg,     cnt_next;
    logic [1:0]        arg_reg,     arg_next;
    logic [15:0]       addr_hi_reg, addr_hi_next;
    logic [7:0]        tx_byte_reg, tx_byte_next;
    logic [7:0]        wdata_reg,   wdata_next;
    logic              is_wr_reg,   is_wr_next;

    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       rx_take;
    logic       tx_ready;
    logic       tx_send;

    ser_byte_io u_byte_io (
        .mclk        (mclk),
        .reset       (reset),
        .sio_rxd     (sio_rxd),
        .sio_rxempty (sio_rxempty),
        .sio_rxe     (sio_rxe),
        .sio_txd     (sio_txd),
        .sio_txfull  (sio_txfull),
        .sio_txe     (sio_txe),
        .rx_valid    (rx_valid),
        .rx_byte     (rx_byte),
        .rx_take     (rx_take),
        .tx_ready    (tx_ready),
        .tx_send     (tx_send),
        .tx_byte     (tx_byte_reg)
    );

    always_ff @(posedge mclk) begin
        if (reset) begin
            state_reg   <= S_CMD;
            addr_reg    <= '0;
            cnt_reg     <= 9'd0;
            arg_reg     <= 2'd0;
            addr_hi_reg <= 16'h0000;
            tx_byte_reg <= 8'h00;
            wdata_reg   <= 8'h00;
            is_wr_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            addr_reg    <= addr_next;
            cnt_reg     <= cnt_next;
            arg_reg     <= arg_next;
            addr_hi_reg <= addr_hi_next;
            tx_byte_reg <= tx_byte_next;
            wdata_reg   <= wdata_next;
            is_wr_reg   <= is_wr_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        addr_next    = addr_reg;
        cnt_next     = cnt_reg;
        arg_next     = arg_reg;
        addr_hi_next = addr_hi_reg;
        tx_byte_next = tx_byte_reg;
        wdata_next   = wdata_reg;
        is_wr_next   = is_wr_reg;
        rx_take      = 1'b0;
        tx_send      = 1'b0;

        case (state_reg)
            S_CMD: begin
                if (rx_valid) begin
                    rx_take = 1'b1;
                    case (rx_byte)
                        OP_PING: begin
                            tx_byte_next = PING_RSP;
                            state_next   = S_TX;
                        end
                        OP_SET_ADDR: begin
                            arg_next   = 2'd2;
                            state_next = S_ADDR;
                        end
                        OP_WRITE: begin
                            is_wr_next = 1'b1;
                            state_next = S_CNT;
                        end
                        OP_READ: begin
                            is_wr_next = 1'b0;
                            state_next = S_CNT;
                        end
                        default: begin
                            tx_byte_next = NAK_BYTE;
                            state_next   = S_TX;
                        end
                    endcase
                end
            end
            S_ADDR: begin
                if (rx_valid) begin
                    rx_take      = 1'b1;
                    addr_hi_next = {addr_hi_reg[7:0], rx_byte};
                    if (arg_reg == 2'd0) begin
                        // Third byte completes the 24-bit big-endian address.
                        addr_next    = ADDR_W'({addr_hi_reg, rx_byte});
                        tx_byte_next = ACK_BYTE;
                        state_next   = S_TX;
                    end else begin
                        arg_next = arg_reg - 2'd1;
                    end
                end
            end
            S_CNT: begin
                if (rx_valid) begin
                    rx_take    = 1'b1;
                    cnt_next   = (rx_byte == 8'h00) ? 9'd256 : {1'b0, rx_byte};
                    state_next = is_wr_reg ? S_WDATA : S_RREQ;
                end
            end
            S_WDATA: begin
                if (rx_valid) begin
                    rx_take    = 1'b1;
                    wdata_next = rx_byte;
                    state_next = S_WREQ;
                end
            end
            S_WREQ: state_next = S_WWAIT;
            S_WWAIT: begin
                if (mem_finish) begin
                    addr_next = addr_reg + ADDR_W'(1);
                    cnt_next  = cnt_reg - 9'd1;
                    if (cnt_reg == 9'd1) begin
                        tx_byte_next = ACK_BYTE;
                        state_next   = S_TX;
                    end else begin
                        state_next = S_WDATA;
                    end
                end
            end
            S_RREQ: state_next = S_RWAIT;
            S_RWAIT: begin
                if (mem_finish) begin
                    tx_byte_next = mem_data_rd;
                    addr_next    = addr_reg + ADDR_W'(1);
                    cnt_next     = cnt_reg - 9'd1;
                    state_next   = S_RTX;
                end
            end
            S_RTX: begin
                if (tx_ready) begin
                    tx_send    = 1'b1;
                    state_next = (cnt_reg == 9'd0) ? S_CMD : S_RREQ;
                end
            end
            S_TX: begin
                if (tx_ready) begin
                    tx_send    = 1'b1;
                    state_next = S_CMD;
                end
            end
            default: state_next = S_CMD;
        endcase
    end

    assign mem_begin_wr = (state_reg == S_WREQ);
    assign mem_begin_rd = (state_reg == S_RREQ);
    assign mem_addr     = addr_reg;
    assign mem_data_wr  = wdata_reg;

endmodule

// File: tb/tb_ser_mem_proto.sv
// Self-checking bench for ser_mem_proto: FIFO/SRAM environment models and a
// command-level reference model that predicts TX bytes, SRAM ops and address.
module tb_ser_mem_proto;

    localparam int AW = 20;

    logic          mclk = 1'b0;
    logic          reset;
    logic [7:0]    sio_rxd = 8'h00;
    logic          sio_rxempty = 1'b1;
    logic          sio_rxe;
    logic [7:0]    sio_txd;
    logic          sio_txfull;
    logic          sio_txe;
    logic          mem_begin_wr;
    logic          mem_begin_rd;
    logic          mem_finish = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data_wr;
    logic [7:0]    mem_data_rd = 8'h00;

    ser_mem_proto dut (
        .mclk         (mclk),
        .reset        (reset),
        .sio_rxd      (sio_rxd),
        .sio_rxempty  (sio_rxempty),
        .sio_rxe      (sio_rxe),
        .sio_txd      (sio_txd),
        .sio_txfull   (sio_txfull),
        .sio_txe      (sio_txe),
        .mem_begin_wr (mem_begin_wr),
        .mem_begin_rd (mem_begin_rd),
        .mem_finish   (mem_finish),
        .mem_addr     (mem_addr),
        .mem_data_wr  (mem_data_wr),
        .mem_data_rd  (mem_data_rd)
    );

    always #5 mclk = ~mclk;

    typedef logic [7:0] bq_t[$];

    // Environment state: written only by the environment process below.
    bq_t         tx_got;
    logic [31:0] op_log[$];
    int          rx_rd = 0;
    int          rx_underflow = 0;
    int          txe_in_full = 0;
    int          overlap = 0;
    logic [7:0]  sram[int];

    // Stimulus state: written only by the initial block.
    bq_t         rx_src;
    logic [7:0]  pre_mem[int];
    int          force_lat = -1;

    // Reference model state.
    bq_t         exp_tx;
    logic [31:0] exp_ops[$];
    logic [7:0]  ref_mem[int];
    int          model_addr = 0;
    int          tx_base = 0;
    int          op_base = 0;

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [7:0] dflt(input int a);
        return 8'(a) ^ 8'(a >> 8) ^ 8'h3C;
    endfunction

    // RX FIFO, TX FIFO and SRAM controller models.
    logic        full_q = 1'b0;
    logic        pend = 1'b0;
    int          cd = 0;
    logic        cur_wr = 1'b0;
    logic [AW-1:0] cur_addr = '0;
    logic [7:0]  cur_data = 8'h00;
    always begin
        @(posedge mclk);
        if (sio_rxe) begin
            if (rx_rd < rx_src.size()) rx_rd++;
            else rx_underflow++;
        end
        if (sio_txe) begin
            tx_got.push_back(sio_txd);
            if (full_q) txe_in_full++;
        end
        full_q = sio_txfull;
        if (mem_begin_wr || mem_begin_rd) begin
            if (pend) overlap++;
            pend     = 1'b1;
            cd       = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
            cur_wr   = mem_begin_wr;
            cur_addr = mem_addr;
            cur_data = mem_data_wr;
            op_log.push_back({3'b000, cur_wr, cur_addr, cur_wr ? cur_data : 8'h00});
        end
        @(negedge mclk);
        mem_finish  = 1'b0;
        mem_data_rd = 8'($urandom);
        if (pend) begin
            if (cd == 0) begin
                mem_finish = 1'b1;
                pend       = 1'b0;
                if (cur_wr) sram[int'(cur_addr)] = cur_data;
                else if (sram.exists(int'(cur_addr))) mem_data_rd = sram[int'(cur_addr)];
                else if (pre_mem.exists(int'(cur_addr))) mem_data_rd = pre_mem[int'(cur_addr)];
                else mem_data_rd = dflt(int'(cur_addr));
            end else begin
                cd--;
            end
        end
        sio_rxempty = (rx_rd >= rx_src.size());
        sio_rxd     = sio_rxempty ? 8'h00 : rx_src[rx_rd];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_read(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    // Interprets a host byte stream command by command.
    task automatic model_cmd(input bq_t cmd);
        int i = 0;
        int n;
        exp_tx.delete();
        exp_ops.delete();
        while (i < cmd.size()) begin
            logic [7:0] op = cmd[i];
            i++;
            case (op)
                8'h00: exp_tx.push_back(8'hA5);
                8'h01: begin
                    model_addr = (int'(cmd[i]) * 65536 + int'(cmd[i+1]) * 256 + int'(cmd[i+2]))
                                 % (1 << AW);
                    i += 3;
                    exp_tx.push_back(8'h06);
                end
                8'h02: begin
                    n = (cmd[i] == 8'h00) ? 256 : int'(cmd[i]);
                    i++;
                    for (int k = 0; k < n; k++) begin
                        exp_ops.push_back({3'b000, 1'b1, AW'(model_addr), cmd[i]});
                        ref_mem[model_addr] = cmd[i];
                        i++;
                        model_addr = (model_addr + 1) % (1 << AW);
                    end
                    exp_tx.push_back(8'h06);
                end
                8'h03: begin
                    n = (cmd[i] == 8'h00) ? 256 : int'(cmd[i]);
                    i++;
                    for (int k = 0; k < n; k++) begin
                        exp_ops.push_back({3'b000, 1'b0, AW'(model_addr), 8'h00});
                        exp_tx.push_back(ref_read(model_addr));
                        model_addr = (model_addr + 1) % (1 << AW);
                    end
                end
                default: exp_tx.push_back(8'h15);
            endcase
        end
    endtask

    task automatic push_rx(input bq_t cmd);
        foreach (cmd[k]) rx_src.push_back(cmd[k]);
    endtask

    task automatic finish_check(input string tag);
        int t = 0;
        int ntx;
        int nop;
        while (((tx_got.size() - tx_base) < exp_tx.size() ||
                (op_log.size() - op_base) < exp_ops.size() ||
                rx_rd < rx_src.size()) && t < 30000) begin
            @(posedge mclk);
            t++;
        end
        check({tag, "_done"}, 32'(t < 30000), 32'd1);
        repeat (8) @(posedge mclk);
        #1;
        ntx = tx_got.size() - tx_base;
        nop = op_log.size() - op_base;
        check({tag, "_txcnt"}, ntx, exp_tx.size());
        check({tag, "_opcnt"}, nop, exp_ops.size());
        for (int k = 0; k < ntx && k < exp_tx.size(); k++)
            check($sformatf("%s_tx%0d", tag, k), 32'(tx_got[tx_base + k]), 32'(exp_tx[k]));
        for (int k = 0; k < nop && k < exp_ops.size(); k++)
            check($sformatf("%s_op%0d", tag, k), op_log[op_base + k], exp_ops[k]);
        check({tag, "_addr"}, 32'(mem_addr), model_addr);
        $display("txn %s: %0d tx bytes, %0d sram ops, addr %05h", tag, ntx, nop, mem_addr);
        tx_base = tx_got.size();
        op_base = op_log.size();
    endtask

    task automatic run_and_check(input string tag, input bq_t cmd);
        model_cmd(cmd);
        push_rx(cmd);
        finish_check(tag);
    endtask

    initial begin
        bq_t q;
        reset      = 1'b1;
        sio_txfull = 1'b0;
        repeat (4) @(posedge mclk);
        #1;
        check("rst_rxe",   32'(sio_rxe), 0);
        check("rst_txe",   32'(sio_txe), 0);
        check("rst_bwr",   32'(mem_begin_wr), 0);
        check("rst_brd",   32'(mem_begin_rd), 0);
        check("rst_txd",   32'(sio_txd), 0);
        check("rst_wdata", 32'(mem_data_wr), 0);
        check("rst_addr",  32'(mem_addr), 0);
        $display("txn reset: outputs idle");
        @(negedge mclk);
        reset = 1'b0;

        q = '{8'h00};
        run_and_check("ping", q);

        // Preloaded SRAM contents for the first read burst.
        pre_mem[32'h01234] = 8'h11; ref_mem[32'h01234] = 8'h11;
        pre_mem[32'h01235] = 8'h22; ref_mem[32'h01235] = 8'h22;
        pre_mem[32'h01236] = 8'h33; ref_mem[32'h01236] = 8'h33;
        q = '{8'h01, 8'h00, 8'h12, 8'h34, 8'h03, 8'h03};
        run_and_check("read3", q);

        q = '{8'h01, 8'h00, 8'h12, 8'h34};
        run_and_check("set_addr", q);
        q = '{8'h02, 8'h02, 8'hAA, 8'hBB};
        run_and_check("write2", q);

        q = '{8'h01, 8'h0F, 8'hFF, 8'hFF, 8'h02, 8'h02, 8'($urandom), 8'($urandom)};
        run_and_check("wrap_wr", q);
        q = '{8'h03, 8'h00};
        run_and_check("read256", q);

        q = '{8'h7F};
        run_and_check("nak", q);
        q = '{8'h00};
        run_and_check("ping2", q);

        // TX FIFO held full during a read burst.
        @(negedge mclk);
        sio_txfull = 1'b1;
        q = '{8'h03, 8'h04};
        model_cmd(q);
        push_rx(q);
        repeat (50) @(posedge mclk);
        #1;
        check("stall_no_tx", tx_got.size() - tx_base, 0);
        check("stall_txe_full", txe_in_full, 0);
        @(negedge mclk);
        sio_txfull = 1'b0;
        finish_check("stall_rd");

        // Reset lands between the write request and its completion.
        q = '{8'h01, 8'h0A, 8'hBC, 8'hDE};
        run_and_check("pre_rst_addr", q);
        force_lat = 6;
        q = '{8'h02, 8'h01, 8'h77};
        push_rx(q);
        for (int t = 0; t < 200 && op_log.size() == op_base; t++) @(posedge mclk);
        check("rst_mid_req_seen", op_log.size() - op_base, 1);
        @(negedge mclk);
        reset = 1'b1;
        @(posedge mclk);
        #1;
        check("mid_rst_rxe",   32'(sio_rxe), 0);
        check("mid_rst_txe",   32'(sio_txe), 0);
        check("mid_rst_bwr",   32'(mem_begin_wr), 0);
        check("mid_rst_brd",   32'(mem_begin_rd), 0);
        check("mid_rst_txd",   32'(sio_txd), 0);
        check("mid_rst_wdata", 32'(mem_data_wr), 0);
        check("mid_rst_addr",  32'(mem_addr), 0);
        @(negedge mclk);
        reset = 1'b0;
        repeat (12) @(posedge mclk);
        #1;
        model_addr = 0;
        ref_mem[32'h0ABCDE] = 8'h77;
        check("late_fin_no_tx", tx_got.size() - tx_base, 0);
        check("late_fin_no_op", op_log.size() - op_base, 1);
        check("late_fin_addr", 32'(mem_addr), 0);
        $display("txn reset_mid_write: late finish ignored, addr %05h", mem_addr);
        op_base   = op_log.size();
        force_lat = -1;
        q = '{8'h00};
        run_and_check("ping_after_rst", q);

        // Randomized command mix.
        for (int r = 0; r < 10; r++) begin
            int kind = int'($urandom_range(0, 4));
            int n = int'($urandom_range(1, 6));
            q.delete();
            case (kind)
                0: q = '{8'h00};
                1: q = '{8'h01, 8'($urandom), 8'($urandom), 8'($urandom)};
                2: begin
                    q = '{8'h02, 8'(n)};
                    for (int k = 0; k < n; k++) q.push_back(8'($urandom));
                end
                3: q = '{8'h03, 8'(n)};
                default: q = '{8'($urandom_range(4, 255))};
            endcase
            run_and_check($sformatf("rand%0d_k%0d", r, kind), q);
        end

        check("no_overlap", overlap, 0);
        check("no_rx_underflow", rx_underflow, 0);
        check("no_txe_when_full", txe_in_full, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
